dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory interface: accepts the core's dmem_addr/dmem_wd/dmem_we
//  request, services it from an internal word array after a fixed number of wait states, and
//  returns read data with a one-cycle dmem_ready pulse. dmem_stall feeds the hazard unit to freeze
//  F/D/E/M while a request is in flight. Replaces the zero-latency combinational data memory model.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of two, >= 4
//  LATENCY      2    cycles from acceptance to dmem_ready; legal range 1..15
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  reset      in   1   asynchronous, active-high reset
//  dmem_req   in   1   request valid (MEM stage holds a load or store)
//  dmem_we    in   1   1 = store, 0 = load
//  dmem_addr  in   32  byte address; word index = dmem_addr[31:2]
//  dmem_wd    in   32  store data
//  dmem_rd    out  32  load data; valid while dmem_ready=1, held until next response
//  dmem_ready out  1   one-cycle completion pulse
//  dmem_stall out  1   request pending and not completing this cycle
//  dmem_err   out  1   qualified by dmem_ready: misaligned or out-of-range access
// BEHAVIOUR
//  - Reset (async): state=IDLE, wait counter=0, dmem_rd=0, dmem_ready=0, dmem_err=0, latches=0.
//    The memory array is not cleared. Reset during WAIT aborts the transaction: no write occurs.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: when dmem_req=1, latch addr/wd/we into holding registers, set cnt=LATENCY-1.
//      If LATENCY=1, go to RESP; otherwise go to WAIT.
//    WAIT: decrement cnt; when cnt reaches 1, go to RESP.
//    RESP: registered dmem_ready=1 for exactly one cycle, then IDLE.
//  - Timing: a request accepted at edge N gives dmem_ready high in the cycle after edge N+LATENCY-1,
//    i.e. exactly LATENCY cycles after the acceptance cycle.
//  - dmem_stall = dmem_req & ~dmem_ready (combinational). It is high in the acceptance cycle and
//    in every WAIT cycle, and low in the RESP cycle so the pipeline advances.
//  - Store: the array is written at the clock edge that ends the RESP cycle, using latched
//    addr/wd. A store returns dmem_rd = 0.
//  - Load: the array is read at entry to RESP; dmem_rd takes the latched-address word and holds it
//    until the next RESP.
//  - Error: latched addr[1:0]!=0 OR addr[31:2] >= DEPTH_WORDS. Then dmem_err=1 with dmem_ready,
//    no write, dmem_rd=0. No wrap-around of addresses.
//  - Requester inputs may change or drop after acceptance; only latched values are used and the
//    transaction still completes. dmem_req during WAIT/RESP is ignored (no queuing); a new request
//    is accepted only in IDLE. Minimum spacing between back-to-back requests is LATENCY+1 cycles.
//  - Load-after-store to the same word returns the newly stored value (write lands before the
//    next acceptance).
// CONFIGURATION
//  DMEM_BYTE_EN_EN defined:
//    - Adds input dmem_be[3:0], latched with the request.
//    - A store writes only byte lanes with be[i]=1 (lane i = bits 8i+7:8i).
//    - be=4'b0000 is a no-op store that still completes normally.
//    - Misalignment is checked only for full-word stores (be=4'b1111) and loads.
//  DMEM_BYTE_EN_EN undefined: no dmem_be port; every store writes the full word.
// TESTING
//  1. Assert reset mid-WAIT after a store of 0xDEADBEEF to 0x10 -> outputs 0 immediately.
//     Then load 0x10 -> returns the prior contents, not 0xDEADBEEF.
//  2. LATENCY=2: store 0xCAFEF00D @0x40, then load @0x40 -> dmem_ready 2 cycles after each
//     acceptance, dmem_stall high for exactly 2 cycles per access, load returns 0xCAFEF00D.
//  3. Load @0x41, then load @(4*DEPTH_WORDS) -> both give dmem_err=1 with dmem_ready and dmem_rd=0.
//     Neither request modifies the array.
//  4. Store accepted, then dmem_req dropped and dmem_wd changed during WAIT -> original data written.
//     dmem_ready still pulses once.
//  5. LATENCY=1 sweep and LATENCY=15 sweep: 8 back-to-back loads -> each dmem_ready exactly LATENCY
//     cycles after its acceptance; no lost or duplicated responses.
//  6. With DMEM_BYTE_EN_EN: word = 0x11223344, store be=4'b0101 with wd=0xAABBCCDD -> reads
//     back 0x11BB33DD.

Source files
------------

// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the MEM stage (master) and
// the data-memory responder (slave).
// Optional byte-lane enables are present only when DMEM_BYTE_EN_EN is defined.
//
// Handshake: the master raises dmem_req with dmem_we/dmem_addr/dmem_wd (and
// dmem_be) valid. The slave samples them on the clock edge where it is idle
// and dmem_req=1. After that edge the master may change or drop them.
// Completion is a single-cycle dmem_ready pulse. dmem_rd and dmem_err are
// valid while dmem_ready=1, and dmem_rd holds until the next response.
// dmem_stall = dmem_req & ~dmem_ready freezes the pipeline until completion.
// dmem_dbg_state mirrors the responder FSM state for observation.
interface dmem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;
  logic        dmem_ready;
  logic        dmem_stall;
  logic        dmem_err;
  logic [1:0]  dmem_dbg_state;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  dmem_be;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wd, dmem_be,
    input  dmem_rd, dmem_ready, dmem_stall, dmem_err, dmem_dbg_state
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wd, dmem_be,
    output dmem_rd, dmem_ready, dmem_stall, dmem_err, dmem_dbg_state
  );
`else
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wd,
    input  dmem_rd, dmem_ready, dmem_stall, dmem_err, dmem_dbg_state
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wd,
    output dmem_rd, dmem_ready, dmem_stall, dmem_err, dmem_dbg_state
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// A request is latched in IDLE, counted down in WAIT, and answered in RESP
// with a one-cycle ready pulse. Stores commit at the edge that ends RESP.
// Optional feature macro: DMEM_BYTE_EN_EN, which adds per-byte store enables.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic [31:0] rd_q, rd_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be_q, be_d;
`endif

  logic [31:0]   mem [DEPTH_WORDS];
  logic          enter_resp;
  logic          acc_err;
  logic          misaligned;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          do_write;

  // Next-state, request latching and response formation.
  // The error check and array read use the *_d values, which are the
  // transaction being answered. This keeps the LATENCY=1 case correct.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    we_d       = we_q;
    rd_d       = rd_q;
    ready_d    = 1'b0;
    err_d      = err_q;
`ifdef DMEM_BYTE_EN_EN
    be_d       = be_q;
`endif
    enter_resp = 1'b0;
    misaligned = 1'b0;
    acc_err    = 1'b0;
    rd_idx     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.dmem_req) begin
          addr_d = bus.dmem_addr;
          wd_d   = bus.dmem_wd;
          we_d   = bus.dmem_we;
`ifdef DMEM_BYTE_EN_EN
          be_d   = bus.dmem_be;
`endif
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef DMEM_BYTE_EN_EN
    // Partial-lane stores may target any byte address within the word.
    misaligned = (addr_d[1:0] != 2'b00) && (!we_d || (be_d == 4'b1111));
`else
    misaligned = (addr_d[1:0] != 2'b00);
`endif
    acc_err = misaligned || (addr_d[31:2] >= 30'(DEPTH_WORDS));
    rd_idx  = addr_d[AW+1:2];

    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = acc_err;
      rd_d    = (acc_err || we_d) ? 32'd0 : mem[rd_idx];
    end
  end

  // Control and response registers. An async reset aborts any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      we_q    <= 1'b0;
      rd_q    <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
      be_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
`ifdef DMEM_BYTE_EN_EN
      be_q    <= be_d;
`endif
    end
  end

  // The store commits only when RESP completes without error.
  assign do_write = (state_q == S_RESP) && we_q && !err_q;
  assign wr_idx   = addr_q[AW+1:2];

  // Word array write port. The array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
`ifdef DMEM_BYTE_EN_EN
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[wr_idx][8*i +: 8] <= wd_q[8*i +: 8];
      end
`else
      mem[wr_idx] <= wd_q;
`endif
    end
  end

  assign bus.dmem_rd        = rd_q;
  assign bus.dmem_ready     = ready_q;
  assign bus.dmem_err       = err_q;
  assign bus.dmem_stall     = bus.dmem_req & ~ready_q;
  assign bus.dmem_dbg_state = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Three instances use LATENCY 1, 2 and 15 and share the same clock and reset.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;

  // Clock generation.
  always #5 clk = ~clk;

  dmem_if bus0();
  dmem_if bus1();
  dmem_if bus2();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1))  dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2))  dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  logic        req_v  [3];
  logic        we_v   [3];
  logic [31:0] addr_v [3];
  logic [31:0] wd_v   [3];
  logic [31:0] rd_o   [3];
  logic        ready_o[3];
  logic        stall_o[3];
  logic        err_o  [3];
  logic [1:0]  st_o   [3];
  int          lat_c  [3] = '{1, 2, 15};

  assign bus0.dmem_req = req_v[0];  assign bus0.dmem_we = we_v[0];
  assign bus0.dmem_addr = addr_v[0]; assign bus0.dmem_wd = wd_v[0];
  assign bus1.dmem_req = req_v[1];  assign bus1.dmem_we = we_v[1];
  assign bus1.dmem_addr = addr_v[1]; assign bus1.dmem_wd = wd_v[1];
  assign bus2.dmem_req = req_v[2];  assign bus2.dmem_we = we_v[2];
  assign bus2.dmem_addr = addr_v[2]; assign bus2.dmem_wd = wd_v[2];
  assign rd_o[0] = bus0.dmem_rd; assign ready_o[0] = bus0.dmem_ready; assign stall_o[0] = bus0.dmem_stall;
  assign err_o[0] = bus0.dmem_err; assign st_o[0] = bus0.dmem_dbg_state;
  assign rd_o[1] = bus1.dmem_rd; assign ready_o[1] = bus1.dmem_ready; assign stall_o[1] = bus1.dmem_stall;
  assign err_o[1] = bus1.dmem_err; assign st_o[1] = bus1.dmem_dbg_state;
  assign rd_o[2] = bus2.dmem_rd; assign ready_o[2] = bus2.dmem_ready; assign stall_o[2] = bus2.dmem_stall;
  assign err_o[2] = bus2.dmem_err; assign st_o[2] = bus2.dmem_dbg_state;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0] be_v[3];
  assign bus0.dmem_be = be_v[0];
  assign bus1.dmem_be = be_v[1];
  assign bus2.dmem_be = be_v[2];
`endif

  int error_count = 0;
  int check_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one transaction on instance k, starting in an IDLE cycle.
  // It checks latency, stall cycles and the single-cycle ready pulse, and
  // returns at an IDLE cycle. With drop=1 the inputs are scrambled after
  // acceptance.
  task automatic access(input int k, input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input bit drop,
                        output logic [31:0] rd, output logic err);
    int c;
    int stalls;
    bit seen;
    req_v[k] = 1'b1; we_v[k] = we; addr_v[k] = addr; wd_v[k] = wd;
`ifdef DMEM_BYTE_EN_EN
    be_v[k] = be;
`endif
    #1;
    stalls = stall_o[k] ? 1 : 0;
    @(posedge clk); #1;
    if (drop) begin
      req_v[k] = 1'b0; wd_v[k] = ~wd; addr_v[k] = addr + 32'h4; we_v[k] = ~we;
`ifdef DMEM_BYTE_EN_EN
      be_v[k] = ~be;
`endif
    end
    c = 1; seen = 1'b0; rd = 32'd0; err = 1'b0;
    while (!seen && c <= 40) begin
      if (ready_o[k]) begin
        seen = 1'b1; rd = rd_o[k]; err = err_o[k];
        if (!drop) check({tag, "_stall_in_resp"}, stall_o[k], 1'b0);
      end else begin
        if (stall_o[k]) stalls++;
        c++;
        @(posedge clk); #1;
      end
    end
    check({tag, "_latency"}, c, lat_c[k]);
    if (!drop) check({tag, "_stall_cycles"}, stalls, lat_c[k]);
    req_v[k] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_pulse"}, ready_o[k], 1'b0);
    if (be == 4'hE) $display("unused");
  endtask

  task automatic load_chk(input int k, input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic err;
    access(k, tag, 1'b0, addr, 32'h0, 4'hF, 1'b0, rd, err);
    check({tag, "_rd"}, rd, exp_rd);
    check({tag, "_err"}, err, exp_err);
  endtask

  task automatic store_chk(input int k, input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input bit drop, input logic exp_err);
    logic [31:0] rd;
    logic err;
    access(k, tag, 1'b1, addr, wd, be, drop, rd, err);
    check({tag, "_rd"}, rd, 32'd0);
    check({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = 32'h0; wd_v[k] = 32'h0;
`ifdef DMEM_BYTE_EN_EN
      be_v[k] = 4'hF;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready%0d", k), ready_o[k], 1'b0);
      check($sformatf("reset_rd%0d", k), rd_o[k], 32'd0);
      check($sformatf("reset_err%0d", k), err_o[k], 1'b0);
      check($sformatf("reset_stall%0d", k), stall_o[k], 1'b0);
      check($sformatf("reset_state%0d", k), st_o[k], 2'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // An async reset mid-WAIT (LATENCY=15) cancels the pending store.
    store_chk(2, "t1_prior_st", 32'h10, 32'h01020304, 4'hF, 1'b0, 1'b0);
    load_chk(2, "t1_prior_ld", 32'h10, 32'h01020304, 1'b0);
    req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 32'h10; wd_v[2] = 32'hDEADBEEF;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("t1_stall_wait", stall_o[2], 1'b1);
    reset = 1'b1;
    #1;
    check("t1_abort_ready", ready_o[2], 1'b0);
    check("t1_abort_rd", rd_o[2], 32'd0);
    check("t1_abort_err", err_o[2], 1'b0);
    check("t1_abort_state", st_o[2], 2'd0);
    req_v[2] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    load_chk(2, "t1_after_ld", 32'h10, 32'h01020304, 1'b0);

    // Basic store/load at LATENCY=2.
    store_chk(1, "t2_st", 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    load_chk(1, "t2_ld", 32'h40, 32'hCAFEF00D, 1'b0);

    // Error accesses: misaligned and out of range, with no writes and no wrap.
    store_chk(1, "t3_w0", 32'h0, 32'h55AA0001, 4'hF, 1'b0, 1'b0);
    load_chk(1, "t3_pre", 32'h40, 32'hCAFEF00D, 1'b0);
    load_chk(1, "t3_mis_ld", 32'h41, 32'h0, 1'b1);
    load_chk(1, "t3_oor_ld", 32'h400, 32'h0, 1'b1);
    store_chk(1, "t3_mis_st", 32'h41, 32'hBAD0BAD0, 4'hF, 1'b0, 1'b1);
    store_chk(1, "t3_oor_st", 32'h400, 32'hBAD1BAD1, 4'hF, 1'b0, 1'b1);
    load_chk(1, "t3_w40", 32'h40, 32'hCAFEF00D, 1'b0);
    load_chk(1, "t3_w0_ld", 32'h0, 32'h55AA0001, 1'b0);

    // Inputs change after acceptance; the latched values still commit.
    store_chk(1, "t4_neigh", 32'h84, 32'h12345678, 4'hF, 1'b0, 1'b0);
    store_chk(1, "t4_drop", 32'h80, 32'h0BADF00D, 4'hF, 1'b1, 1'b0);
    load_chk(1, "t4_ld", 32'h80, 32'h0BADF00D, 1'b0);
    load_chk(1, "t4_neigh_ld", 32'h84, 32'h12345678, 1'b0);

    // Back-to-back sweeps at LATENCY=1 and LATENCY=15.
    for (int s = 0; s < 2; s++) begin
      int k;
      k = (s == 0) ? 0 : 2;
      for (int i = 0; i < 8; i++)
        store_chk(k, $sformatf("t5_st%0d_%0d", k, i), 32'h100 + 32'(4 * i),
                  32'hA0000000 | (32'(k) << 16) | (32'(i) * 32'h1111), 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
        load_chk(k, $sformatf("t5_ld%0d_%0d", k, i), 32'h100 + 32'(4 * i),
                 32'hA0000000 | (32'(k) << 16) | (32'(i) * 32'h1111), 1'b0);
    end

`ifdef DMEM_BYTE_EN_EN
    // Byte-lane stores.
    store_chk(1, "t6_full", 32'hC0, 32'h11223344, 4'hF, 1'b0, 1'b0);
    store_chk(1, "t6_part", 32'hC0, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
    load_chk(1, "t6_ld", 32'hC0, 32'h11BB33DD, 1'b0);
    store_chk(1, "t6_noop", 32'hC0, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0);
    load_chk(1, "t6_ld2", 32'hC0, 32'h11BB33DD, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end
endmodule
